div_unit: RTL and testbench

- Multi-cycle radix-2 restoring divider in the execute stage.
- Serves DIV/DIVU and produces the HI/LO result pair.
- Drives the execute-stage divider stall consumed by the pipeline hazard/stall logic.
- Handshake: the requester holds start; the unit keeps the stall asserted until the result is ready.

---
 rtl/div_if.sv | 26 ++
 rtl/div_unit.sv | 132 +++++++++++++
 tb/tb_div_unit.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/div_if.sv
// Divider request/response bundle between the execute stage and div_unit.
//   master (requester): drives a, b, signed_div, start, annul;
//                       receives result, ready, stall_div.
//   slave  (div_unit) : the reverse.
interface div_if #(
    parameter int unsigned DATA_W = 32
);
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
    logic                signed_div;
    logic                start;
    logic                annul;
    logic [2*DATA_W-1:0] result;
    logic                ready;
    logic                stall_div;

    modport master (
        output a, b, signed_div, start, annul,
        input  result, ready, stall_div
    );

    modport slave (
        input  a, b, signed_div, start, annul,
        output result, ready, stall_div
    );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the execute stage.
// Ports:
//   clk        rising-edge pipeline clock
//   rst        asynchronous active-high reset
//   bus.a/b    dividend / divisor, captured when an operation starts
//   bus.signed_div  1 = two's complement divide, 0 = unsigned
//   bus.start  request, held by the E-stage instruction until ready
//   bus.annul  flush; aborts any operation in progress
//   bus.result {remainder (HI), quotient (LO)}, held until the next completion
//   bus.ready  registered one-cycle completion pulse
//   bus.stall_div  combinational start & ~ready for the hazard logic
module div_unit #(
    parameter int unsigned DATA_W = 32
) (
    input  logic clk,
    input  logic rst,
    div_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIVZERO = 2'd1,
        DIV_ON  = 2'd2,
        DIV_END = 2'd3
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   rem_q;
    logic [DATA_W-1:0]   quo_q;
    logic [DATA_W-1:0]   dvs_q;
    logic                sgn_quo_q;
    logic                sgn_rem_q;
    logic [2*DATA_W-1:0] result_q;
    logic                ready_q;

    logic [DATA_W:0]     shifted_d;
    logic [DATA_W:0]     diff_d;
    logic                borrow_d;
    logic [DATA_W-1:0]   rem_d;
    logic [DATA_W-1:0]   quo_d;
    logic [DATA_W-1:0]   fix_quo_d;
    logic [DATA_W-1:0]   fix_rem_d;
    logic [DATA_W-1:0]   abs_a_d;
    logic [DATA_W-1:0]   abs_b_d;
    logic                neg_a_d;
    logic                neg_b_d;

    // One restoring step plus sign fix-up of that step's outcome.
    always_comb begin
        // The shifted remainder can reach 2*divisor-1, so it needs DATA_W+1 bits;
        // bit DATA_W of the difference is then exactly the borrow.
        shifted_d = {rem_q, quo_q[DATA_W-1]};
        diff_d    = shifted_d - {1'b0, dvs_q};
        borrow_d  = diff_d[DATA_W];
        rem_d     = borrow_d ? shifted_d[DATA_W-1:0] : diff_d[DATA_W-1:0];
        quo_d     = {quo_q[DATA_W-2:0], ~borrow_d};
        fix_quo_d = sgn_quo_q ? -quo_d : quo_d;
        fix_rem_d = sgn_rem_q ? -rem_d : rem_d;

        neg_a_d   = bus.signed_div & bus.a[DATA_W-1];
        neg_b_d   = bus.signed_div & bus.b[DATA_W-1];
        abs_a_d   = neg_a_d ? -bus.a : bus.a;
        abs_b_d   = neg_b_d ? -bus.b : bus.b;
    end

    assign bus.result    = result_q;
    assign bus.ready     = ready_q;
    assign bus.stall_div = bus.start & ~ready_q;

    // Control FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            sgn_quo_q <= 1'b0;
            sgn_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            if (bus.annul) begin
                // A ready pulse already on the bus this cycle is left to stand.
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.start) begin
                            if (bus.b == '0) begin
                                state_q <= DIVZERO;
                            end else begin
                                state_q   <= DIV_ON;
                                quo_q     <= abs_a_d;
                                dvs_q     <= abs_b_d;
                                rem_q     <= '0;
                                cnt_q     <= '0;
                                sgn_quo_q <= neg_a_d ^ neg_b_d;
                                sgn_rem_q <= neg_a_d;
                            end
                        end
                    end
                    DIVZERO: begin
                        result_q <= '0;
                        ready_q  <= 1'b1;
                        state_q  <= DIV_END;
                    end
                    DIV_ON: begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        // Result and ready are registered on the way into DIV_END.
                        if (cnt_q == CNT_W'(DATA_W - 1)) begin
                            result_q <= {fix_rem_d, fix_quo_d};
                            ready_q  <= 1'b1;
                            state_q  <= DIV_END;
                        end
                    end
                    DIV_END: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases, randomized operands
// against an integer-arithmetic reference, annul, async reset and back-to-back.
module tb_div_unit;
    localparam int unsigned DATA_W = 32;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [63:0] last_res;

    div_if #(.DATA_W(DATA_W)) dif ();

    div_unit #(.DATA_W(DATA_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: truncating integer division on 64-bit values, low words kept.
    function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y,
                                            input logic s);
        longint q;
        longint r;
        if (y == 32'd0) return 64'd0;
        if (s) begin
            q = longint'($signed(x)) / longint'($signed(y));
            r = longint'($signed(x)) % longint'($signed(y));
        end else begin
            q = longint'({32'd0, x}) / longint'({32'd0, y});
            r = longint'({32'd0, x}) % longint'({32'd0, y});
        end
        return {r[31:0], q[31:0]};
    endfunction

    // Issues one operation from cycle 0 (called at posedge+1) and checks ready,
    // stall_div every cycle and the result on the ready cycle.
    task automatic run_op(input string name, input logic [31:0] ta, input logic [31:0] bv,
                          input logic ts, input bit keep_start, input int annul_at);
        int          lat;
        logic [63:0] exp_res;
        lat     = (bv == 32'd0) ? 2 : 33;
        exp_res = ref_div(ta, bv, ts);
        dif.a          = ta;
        dif.b          = bv;
        dif.signed_div = ts;
        dif.start      = 1'b1;
        for (int c = 0; c <= lat; c++) begin
            if (c == annul_at) dif.annul = 1'b1;
            @(negedge clk);
            n_checks++;
            if (dif.ready !== 1'(c == lat)) begin
                n_fail++;
                $display("FAIL %s ready cycle %0d: got %b expected %b", name, c, dif.ready, c == lat);
            end
            n_checks++;
            if (dif.stall_div !== 1'(c != lat)) begin
                n_fail++;
                $display("FAIL %s stall_div cycle %0d: got %b expected %b", name, c, dif.stall_div, c != lat);
            end
            if (c == lat) begin
                n_checks++;
                if (dif.result !== exp_res) begin
                    n_fail++;
                    $display("FAIL %s result a=%h b=%h s=%b: got %h expected %h",
                             name, ta, bv, ts, dif.result, exp_res);
                end
            end
            @(posedge clk);
            #1;
            dif.annul = 1'b0;
            // Operands are captured already; disturbing them must not matter.
            if (c == 1 && !keep_start) begin
                dif.a          = $urandom;
                dif.b          = $urandom;
                dif.signed_div = 1'($urandom_range(0, 1));
            end
        end
        if (!keep_start) dif.start = 1'b0;
        last_res = exp_res;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (dif.result !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_result: got %h expected 0", dif.result);
        end
        n_checks++;
        if (dif.ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 0", dif.ready);
        end
        n_checks++;
        if (dif.stall_div !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_stall: got %b expected 0", dif.stall_div);
        end
    endtask

    task automatic test_directed();
        run_op("udiv_100_7", 32'd100, 32'd7, 1'b0, 1'b0, -1);
        idle_cycles(1);
        run_op("sdiv_m7_2", 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 1'b0, -1);
        idle_cycles(2);
        run_op("sdiv_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, -1);
        run_op("udiv_max_1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, -1);
        idle_cycles(1);
        run_op("div_zero", 32'd5, 32'd0, 1'b0, 1'b0, -1);
        idle_cycles(1);
        run_op("sdiv_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, -1);
        run_op("sdiv_zero", 32'h8000_0000, 32'd0, 1'b1, 1'b0, -1);
    endtask

    task automatic test_random();
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        int          sel;
        for (int i = 0; i < 24; i++) begin
            ra  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0)      rb = 32'd0;
            else if (sel <= 2) rb = $urandom_range(1, 15);
            else if (sel == 3) rb = -32'($urandom_range(1, 15));
            else               rb = $urandom;
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            rs = 1'($urandom_range(0, 1));
            run_op("random", ra, rb, rs, 1'b0, -1);
            idle_cycles($urandom_range(0, 2));
        end
    endtask

    task automatic check_quiet(input string name, input int n, input logic [63:0] prev);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            n_checks++;
            if (dif.ready !== 1'b0 || dif.result !== prev) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got ready=%b result=%h expected ready=0 result=%h",
                         name, c, dif.ready, dif.result, prev);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_annul();
        logic [63:0] prev;
        prev = last_res;
        dif.a          = 32'd1000;
        dif.b          = 32'd3;
        dif.signed_div = 1'b0;
        dif.start      = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            if (c == 10) dif.annul = 1'b1;
            @(negedge clk);
            n_checks++;
            if (dif.stall_div !== 1'b1) begin
                n_fail++;
                $display("FAIL annul_stall cycle %0d: got %b expected 1", c, dif.stall_div);
            end
            @(posedge clk);
            #1;
        end
        dif.annul = 1'b0;
        dif.start = 1'b0;
        check_quiet("annul_abort", 40, prev);

        // annul beats start while idle
        dif.b     = 32'd5;
        dif.start = 1'b1;
        dif.annul = 1'b1;
        check_quiet("annul_prio_hold", 5, prev);
        dif.start = 1'b0;
        dif.annul = 1'b0;
        check_quiet("annul_prio_after", 40, prev);

        // fresh operation after abort has normal latency
        run_op("after_annul", 32'd1000, 32'd3, 1'b0, 1'b0, -1);
        // annul coincident with the ready cycle leaves the pulse in place
        run_op("annul_at_end", 32'd77, 32'd5, 1'b0, 1'b0, 33);
        idle_cycles(1);
    endtask

    task automatic test_async_reset();
        dif.a          = 32'd12345;
        dif.b          = 32'd11;
        dif.signed_div = 1'b0;
        dif.start      = 1'b1;
        idle_cycles(15);
        #2;
        rst       = 1'b1;
        dif.start = 1'b0;
        #1;
        test_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_res = 64'd0;
        check_quiet("post_reset", 3, 64'd0);
        run_op("after_reset", 32'hFFFF_FF9C, 32'd10, 1'b1, 1'b0, -1);
    endtask

    task automatic test_back_to_back();
        run_op("b2b_first", 32'd100, 32'd7, 1'b0, 1'b1, -1);
        run_op("b2b_second", 32'hDEAD_BEEF, 32'h0000_1234, 1'b0, 1'b0, -1);
        idle_cycles(1);
        run_op("b2b_zero_first", 32'd9, 32'd0, 1'b0, 1'b1, -1);
        run_op("b2b_zero_second", 32'hFFFF_FF00, 32'd3, 1'b1, 1'b0, -1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        last_res       = 64'd0;
        rst            = 1'b1;
        dif.a          = 32'd0;
        dif.b          = 32'd0;
        dif.signed_div = 1'b0;
        dif.start      = 1'b0;
        dif.annul      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        idle_cycles(1);
        test_directed();
        test_random();
        test_annul();
        test_back_to_back();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
